// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the fetch-stage program-counter controller.
//   RESET_PC_DEF : first fetch address after reset (boot ROM entry)
//   EXC_PC_DEF   : general exception vector. The core selects between this
//                  and EPC upstream and presents the result on exc_target.
//   pc_state_e   : controller FSM states. 2'b11 is a spare encoding.
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC_DEF   = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC priority mux for the fetch stage.
// Inputs:
//   flush_exc / exc_target      : exception or eret redirect (highest priority)
//   pend_valid / pend_target    : redirect buffered while fetch was stalled
//   req_d                       : decode-stage redirect accepted this cycle
//   jr_d / jr_target_d          : JR/JALR target (forwarded rs)
//   jump_d / jump_target_d      : J/JAL target
//   branch_target_d             : conditional branch target
//   pc_plus4_f                  : sequential fall-through address
// Outputs:
//   dec_target                  : decode redirect target (jr > jump > branch)
//   next_pc                     : address to load when the PC updates
// ---------------------------------------------------------------------------
module pc_next_sel
  import pc_ctrl_pkg::*;
(
  input  logic        flush_exc,
  input  logic [31:0] exc_target,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  input  logic        req_d,
  input  logic        jr_d,
  input  logic [31:0] jr_target_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  input  logic [31:0] branch_target_d,
  input  logic [31:0] pc_plus4_f,
  output logic [31:0] dec_target,
  output logic [31:0] next_pc
);

  // Decode redirect target. Only one of jr/jump/branch is legal at a time,
  // the fixed priority just keeps the mux well defined if that is violated.
  always_comb begin
    dec_target = branch_target_d;
    if (jr_d) begin
      dec_target = jr_target_d;
    end else if (jump_d) begin
      dec_target = jump_target_d;
    end
  end

  // A buffered redirect outranks a fresh decode request: while a redirect is
  // pending, decode holds the delay slot, which can never itself redirect.
  always_comb begin
    next_pc = pc_plus4_f;
    if (flush_exc) begin
      next_pc = exc_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else if (req_d) begin
      next_pc = dec_target;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl
// Fetch-stage program-counter controller. Owns the PC register, picks the
// next fetch address and buffers a decode redirect that arrives while fetch
// is stalled so that a taken branch is never lost.
// Ports:
//   clk, rst                : clock (rising edge), async active-high reset
//   stall_f                 : hold the PC, fetch not accepted
//   stall_d                 : decode stalled, decode branch inputs invalid
//   flush_exc, exc_target   : exception/eret redirect, honoured even if stalled
//   branch_d, cmp_y,
//   branch_target_d         : conditional branch and its comparator result
//   jump_d, jump_target_d   : J/JAL
//   jr_d, jr_target_d       : JR/JALR
//   pc_f, pc_plus4_f        : current fetch address and its successor
//   inst_en_f               : instruction memory enable (low only in BOOT)
//   taken_d                 : decode redirect accepted this cycle
//   in_ds_f                 : instruction at pc_f is a delay slot
//   adel_f                  : pc_f misaligned (exception raised downstream)
// ---------------------------------------------------------------------------
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_exc,
  input  logic [31:0] exc_target,
  input  logic        branch_d,
  input  logic        cmp_y,
  input  logic [31:0] branch_target_d,
  input  logic        jump_d,
  input  logic [31:0] jump_target_d,
  input  logic        jr_d,
  input  logic [31:0] jr_target_d,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        inst_en_f,
  output logic        taken_d,
  output logic        in_ds_f,
  output logic        adel_f
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] dec_target;
  logic [31:0] next_pc;
  logic        req_d;
  logic        pend_valid;

  // Decode-side redirect request; decode inputs are meaningless while it stalls.
  assign req_d      = ~stall_d & ((branch_d & cmp_y) | jump_d | jr_d);
  assign taken_d    = req_d;
  assign in_ds_f    = ~stall_d & (branch_d | jump_d | jr_d);
  assign pend_valid = (state_q == ST_PEND);

  assign pc_f       = pc_q;
  assign pc_plus4_f = pc_q + 32'd4;
  assign adel_f     = |pc_q[1:0];

  pc_next_sel u_next_sel (
    .flush_exc       (flush_exc),
    .exc_target      (exc_target),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target_q),
    .req_d           (req_d),
    .jr_d            (jr_d),
    .jr_target_d     (jr_target_d),
    .jump_d          (jump_d),
    .jump_target_d   (jump_target_d),
    .branch_target_d (branch_target_d),
    .pc_plus4_f      (pc_plus4_f),
    .dec_target      (dec_target),
    .next_pc         (next_pc)
  );

  // Controller FSM. BOOT spends one cycle with fetch disabled before RUN.
  // In RUN a redirect that meets a stalled fetch is parked in pend_target;
  // PEND then releases it on the first unstalled edge. An exception redirect
  // wins everywhere except BOOT and throws away any parked redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    inst_en_f     = 1'b1;
    case (state_q)
      ST_BOOT: begin
        inst_en_f = 1'b0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (flush_exc) begin
          pc_d = next_pc;
        end else if (req_d && stall_f) begin
          pend_target_d = dec_target;
          state_d       = ST_PEND;
        end else if (!stall_f) begin
          pc_d = next_pc;
        end
      end
      ST_PEND: begin
        if (flush_exc) begin
          pc_d          = next_pc;
          pend_target_d = '0;
          state_d       = ST_RUN;
        end else if (!stall_f) begin
          pc_d    = next_pc;
          state_d = ST_RUN;
        end
      end
      default: begin
        // The spare encoding is unreachable; recover through BOOT.
        inst_en_f = 1'b0;
        state_d   = ST_BOOT;
      end
    endcase
  end

  // State, PC and parked-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule
